imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//
// Boot-time program loader. It receives a program image as a byte stream from
// the MMIO serial receiver and writes it into instruction memory one 32-bit
// word at a time. The CPU core is held in reset until a load completes
// successfully.
//
// Stream format, all fields little-endian:
//   N[7:0], N[15:8]                 word count
//   N x { b0, b1, b2, b3 }          instruction words
//   csum                            only when LOADER_CHECKSUM_EN is defined
//
// Optional feature macro: LOADER_CHECKSUM_EN
//   When this macro is defined, the loader keeps a running 8-bit sum of every
//   length byte and data byte. It then takes one trailing byte and finishes
//   in DONE only if (sum + byte) mod 256 == 0. Otherwise it finishes in ERR.
//   When the macro is undefined, ERR is never entered.
//
// Ports
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   start      in   load request pulse; honoured only in IDLE / DONE / ERR
//   rx_data    in   [7:0] received byte
//   rx_valid   in   rx_data holds a byte
//   rx_ready   out  loader accepts a byte (LEN0, LEN1, DATA, CSUM)
//   imem_we    out  one-cycle instruction-memory write strobe
//   imem_addr  out  [31:0] word-aligned byte address; 0 outside WRITE
//   imem_wd    out  [31:0] word being written; holds its value between writes
//   cpu_reset  out  core reset; low only in DONE
//   done       out  last load completed successfully
//   error      out  last load failed its checksum
// ---------------------------------------------------------------------------
module imem_loader (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wd,
    output logic        cpu_reset,
    output logic        done,
    output logic        error
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LEN0  = 3'd1;
    localparam logic [2:0] LEN1  = 3'd2;
    localparam logic [2:0] DATA  = 3'd3;
    localparam logic [2:0] WRITE = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;
    localparam logic [2:0] ERR   = 3'd6;
`ifdef LOADER_CHECKSUM_EN
    localparam logic [2:0] CSUM  = 3'd7;
`endif

    logic [2:0]  state;
    logic [15:0] n_words;
    logic [15:0] word_idx;
    logic [1:0]  byte_cnt;
    logic [23:0] word_buf;   // bytes 0..2 of the word being assembled
    logic        xfer;
    logic        last_word;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  csum;
    logic [7:0]  csum_next;
`endif

    assign xfer = rx_valid && rx_ready;

    // Compare in 17 bits so that word_idx + 1 cannot wrap when N = 65535.
    assign last_word = ({1'b0, word_idx} + 17'd1) >= {1'b0, n_words};

`ifdef LOADER_CHECKSUM_EN
    assign csum_next = csum + rx_data;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            n_words  <= '0;
            word_idx <= '0;
            byte_cnt <= '0;
            word_buf <= '0;
            imem_wd  <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state    <= LEN0;
                        n_words  <= '0;
                        word_idx <= '0;
                        byte_cnt <= '0;
`ifdef LOADER_CHECKSUM_EN
                        csum     <= '0;
`endif
                    end
                end
                LEN0: begin
                    if (xfer) begin
                        n_words[7:0] <= rx_data;
`ifdef LOADER_CHECKSUM_EN
                        csum         <= csum_next;
`endif
                        state        <= LEN1;
                    end
                end
                LEN1: begin
                    if (xfer) begin
                        n_words[15:8] <= rx_data;
`ifdef LOADER_CHECKSUM_EN
                        csum          <= csum_next;
`endif
                        if ({rx_data, n_words[7:0]} == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                            state <= CSUM;
`else
                            state <= DONE;
`endif
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (xfer) begin
`ifdef LOADER_CHECKSUM_EN
                        csum     <= csum_next;
`endif
                        byte_cnt <= byte_cnt + 2'd1;
                        case (byte_cnt)
                            2'd0: word_buf[7:0]   <= rx_data;
                            2'd1: word_buf[15:8]  <= rx_data;
                            2'd2: word_buf[23:16] <= rx_data;
                            default: begin
                                // The write data is registered here and left
                                // untouched until the next word, so imem_wd
                                // stays stable outside WRITE.
                                imem_wd <= {rx_data, word_buf};
                                state   <= WRITE;
                            end
                        endcase
                    end
                end
                WRITE: begin
                    if (!last_word) begin
                        word_idx <= word_idx + 16'd1;
                        state    <= DATA;
                    end else begin
`ifdef LOADER_CHECKSUM_EN
                        state <= CSUM;
`else
                        state <= DONE;
`endif
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                CSUM: begin
                    if (xfer) begin
                        state <= (csum_next == 8'd0) ? DONE : ERR;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        rx_ready  = (state == LEN0) || (state == LEN1) || (state == DATA)
`ifdef LOADER_CHECKSUM_EN
                    || (state == CSUM)
`endif
                    ;
        imem_we   = (state == WRITE);
        imem_addr = imem_we ? {14'd0, word_idx, 2'b00} : '0;
        cpu_reset = (state != DONE);
        done      = (state == DONE);
        error     = (state == ERR);
    end

endmodule
